// File: rtl/eda_result_streamer_pkg.sv
// Shared types and helpers for the eda_regional_max result streamer.
package eda_pkg;

  localparam int EDA_I_WIDTH = 2;
  localparam int EDA_J_WIDTH = 2;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } eda_stream_state_t;

  typedef struct packed {
    logic [EDA_I_WIDTH-1:0] i;
    logic [EDA_J_WIDTH-1:0] j;
  } eda_addr_t;

  // Width needed to hold a count of 0..cells inclusive.
  function automatic int eda_cnt_width(input int cells);
    return $clog2(cells + 1);
  endfunction

endpackage

// File: rtl/eda_next_one_finder.sv
// Combinational search for the first set bit at or above a start index.
// Only built when EDA_RESULT_SPARSE_EN is defined; the dense streamer has no use for it.
`ifdef EDA_RESULT_SPARSE_EN
module eda_next_one_finder #(
  parameter int W     = 16,
  parameter int IDX_W = 5
) (
  input  logic [W-1:0]     vec,
  input  logic [IDX_W-1:0] start,
  output logic             found,
  output logic [IDX_W-1:0] idx,
  output logic             is_last
);

  always_comb begin
    found   = 1'b0;
    idx     = '0;
    is_last = 1'b0;
    // Scanning downward leaves the lowest qualifying bit in idx.
    for (int k = W - 1; k >= 0; k--) begin
      if (vec[k] && (k >= int'(start))) begin
        found = 1'b1;
        idx   = IDX_W'(k);
      end
    end
    is_last = found;
    for (int k = 0; k < W; k++) begin
      if (vec[k] && (IDX_W'(k) > idx)) is_last = 1'b0;
    end
  end

endmodule
`endif

// File: rtl/eda_result_streamer.sv
// Snapshots the eda_regional_max bitmap on done rising and streams it as {i,j} beats.
// Build option EDA_RESULT_SPARSE_EN: emit only set pixels instead of every pixel.
module eda_result_streamer
  import eda_pkg::*;
#(
  parameter int M          = 4,
  parameter int N          = 4,
  parameter int I_WIDTH    = 2,
  parameter int J_WIDTH    = 2,
  parameter int ADDR_WIDTH = I_WIDTH + J_WIDTH,
  parameter int CNT_WIDTH  = eda_cnt_width(M * N)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  done_in,
  input  logic [M-1:0][N-1:0]   matrix_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic                  out_bit,
  output logic                  out_last,
  output logic [CNT_WIDTH-1:0]  max_count,
  output logic                  busy,
  output logic                  overrun,
  input  logic                  clr_overrun
);

  localparam int CELLS = M * N;
  localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(CELLS - 1);

  eda_stream_state_t state, state_next;

  logic                 done_d, done_rise;
  logic                 hs, last_hs, capture, drop;
  logic [CELLS-1:0]     matrix_flat, snap;
  logic [CNT_WIDTH-1:0] ptr, ptr_inc;
  logic [CNT_WIDTH-1:0] cap_idx, adv_idx;
  logic                 cap_bit, cap_last, adv_bit, adv_last;

  function automatic logic [CNT_WIDTH-1:0] popcount(input logic [CELLS-1:0] v);
    logic [CNT_WIDTH-1:0] cnt;
    cnt = '0;
    for (int k = 0; k < CELLS; k++) cnt = cnt + CNT_WIDTH'(v[k]);
    return cnt;
  endfunction

  // Flat raster index i*N+j to the packed {i,j} beat address.
  function automatic logic [ADDR_WIDTH-1:0] to_addr(input logic [CNT_WIDTH-1:0] idx);
    int row, col;
    row = int'(idx) / N;
    col = int'(idx) % N;
    return {I_WIDTH'(row), J_WIDTH'(col)};
  endfunction

  assign matrix_flat = matrix_in;
  assign done_rise   = done_in & ~done_d;
  assign hs          = out_valid & out_ready;
  assign last_hs     = hs & out_last;
  // A rising done is only taken when the core is free or the frame is closing this cycle.
  assign capture     = done_rise & ((state == IDLE) | last_hs);
  assign drop        = done_rise & (state == STREAM) & ~last_hs;
  assign ptr_inc     = ptr + CNT_WIDTH'(1);

`ifdef EDA_RESULT_SPARSE_EN
  logic                 cap_found, cap_f_last, adv_found;
  logic [CNT_WIDTH-1:0] cap_f_idx;

  eda_next_one_finder #(.W(CELLS), .IDX_W(CNT_WIDTH)) u_cap_finder (
    .vec     (matrix_flat),
    .start   ({CNT_WIDTH{1'b0}}),
    .found   (cap_found),
    .idx     (cap_f_idx),
    .is_last (cap_f_last)
  );

  eda_next_one_finder #(.W(CELLS), .IDX_W(CNT_WIDTH)) u_adv_finder (
    .vec     (snap),
    .start   (ptr_inc),
    .found   (adv_found),
    .idx     (adv_idx),
    .is_last (adv_last)
  );

  // An empty snapshot still emits one terminating beat at address 0.
  assign cap_idx  = cap_found ? cap_f_idx : '0;
  assign cap_bit  = cap_found;
  assign cap_last = cap_found ? cap_f_last : 1'b1;
  assign adv_bit  = adv_found;
`else
  localparam int IDX_W = (CELLS > 1) ? $clog2(CELLS) : 1;

  assign cap_idx  = '0;
  assign cap_bit  = matrix_flat[0];
  assign cap_last = (CELLS == 1);
  assign adv_idx  = ptr_inc;
  assign adv_bit  = snap[ptr_inc[IDX_W-1:0]];
  assign adv_last = (ptr_inc == LAST_IDX);
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (capture) state_next = STREAM;
      STREAM:  if (last_hs && !capture) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    out_valid = (state == STREAM);
    busy      = (state == STREAM);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      done_d    <= 1'b0;
      ptr       <= '0;
      out_addr  <= '0;
      out_bit   <= 1'b0;
      out_last  <= 1'b0;
      max_count <= '0;
      overrun   <= 1'b0;
    end else begin
      done_d <= done_in;
      if (drop)             overrun <= 1'b1;
      else if (clr_overrun) overrun <= 1'b0;
      if (capture) begin
        max_count <= popcount(matrix_flat);
        ptr       <= cap_idx;
        out_addr  <= to_addr(cap_idx);
        out_bit   <= cap_bit;
        out_last  <= cap_last;
      end else if (last_hs) begin
        ptr      <= '0;
        out_addr <= '0;
        out_bit  <= 1'b0;
        out_last <= 1'b0;
      end else if (hs) begin
        ptr      <= adv_idx;
        out_addr <= to_addr(adv_idx);
        out_bit  <= adv_bit;
        out_last <= adv_last;
      end
    end
  end

  // Snapshot is pure data: only meaningful while streaming, so it carries no reset.
  always_ff @(posedge clk) begin
    if (capture) snap <= matrix_flat;
  end

endmodule

// File: doc/eda_result_streamer.md
# eda_result_streamer

Output-side reader for `eda_regional_max`. The block detects the rising edge of `done` and snapshots the M×N `matrix_output` bitmap. It then streams the result out over a valid/ready interface as `{i,j}`-addressed beats in raster order, which frees the core to start the next image while the result drains. It is the mirror of the write-side loader, which drives `wr_addr`/`pixel_in`/`write_en`.

## Interface
Parameters:
- `M`, 4, image rows
- `N`, 4, image columns
- `I_WIDTH`, 2, row index width, must satisfy ≥ clog2(M)
- `J_WIDTH`, 2, column index width, must satisfy ≥ clog2(N)
- `ADDR_WIDTH`, `I_WIDTH+J_WIDTH`, beat address width, packed as `{i,j}` like `wr_addr`
- `CNT_WIDTH`, clog2(M*N+1), width of the maxima counter

Ports:
- `clk`  in  1  clock
- `reset_n`  in  1  asynchronous, active-low reset
- `done_in`  in  1  `done` from `eda_regional_max`; level signal, only its rising edge is used
- `matrix_in`  in  [M-1:0][N-1:0]  result bitmap, sampled on the `done_in` rising edge
- `out_valid`  out  1  beat valid
- `out_ready`  in  1  consumer ready
- `out_addr`  out  ADDR_WIDTH  `{i,j}` of the current beat
- `out_bit`  out  1  regional-max flag at `out_addr`
- `out_last`  out  1  final beat of the frame
- `max_count`  out  CNT_WIDTH  number of set bits in the current snapshot
- `busy`  out  1  a frame is captured and not yet fully drained
- `overrun`  out  1  sticky flag: a `done_in` edge was dropped
- `clr_overrun`  in  1  synchronous clear for `overrun`

## Operation
- Edge detect: `done_d` is `done_in` registered. `done_rise = done_in & ~done_d`.
- FSM states: `IDLE`, `STREAM`.
- `IDLE`:
  - On `done_rise`, copy `matrix_in` into `snap` and load `max_count` with popcount(`matrix_in`).
  - Set the pointer to the first beat, then go to `STREAM`.
- `STREAM`:
  - `out_valid=1`. `out_addr`, `out_bit` and `out_last` are driven from registers and stay stable while `out_valid & ~out_ready`.
  - A handshake (`out_valid & out_ready`) advances the pointer.
  - A handshake on the `out_last` beat returns the FSM to `IDLE`.
- Beat order: i ascending, and j ascending within each row.
- `done_rise` while in `STREAM`:
  - If it coincides with the last-beat handshake, it is accepted: new snapshot, and the FSM stays in `STREAM` with no bubble.
  - Otherwise the edge is dropped and `overrun` is set. The current snapshot is unaffected.
- `clr_overrun` clears `overrun`. If a set and a clear occur in the same cycle, the set wins.
- `busy = (state == STREAM)`.
- `out_ready` may be asserted while `out_valid=0`; it has no effect.

## Timing
- Reset values: `out_valid=0`, `out_addr=0`, `out_bit=0`, `out_last=0`, `max_count=0`, `busy=0`, `overrun=0`, `done_d=0`, state `IDLE`.
- Latency: first beat `out_valid=1` appears in the cycle after the `done_rise` edge.
- Throughput: one beat per cycle while `out_ready=1`.
- Full (dense) frame: exactly M*N handshakes, with `out_last` on `{M-1,N-1}`.
- `max_count`: updated on capture and held until the next capture.
- Reset mid-stream: everything returns to reset values immediately and the snapshot is discarded.
- `done_in` held high across a whole frame produces no second capture. `done_in` must go low and then high again.

## Configuration
- `EDA_RESULT_SPARSE_EN` undefined (dense mode): every pixel is emitted, M*N beats per frame, `out_bit` = snapshot bit.
- `EDA_RESULT_SPARSE_EN` defined (sparse mode):
  - Only set pixels are emitted, so `out_bit` is always 1 and each beat carries the address of a maximum.
  - The next set bit strictly after the pointer is found combinationally, so throughput stays one beat per cycle.
  - `out_last` is asserted on the last set bit.
  - Empty snapshot: exactly one beat with `out_addr=0`, `out_bit=0`, `out_last=1`, so a frame boundary is always signalled.

## Structure
- Shared package `eda_pkg` holds:
  - `eda_stream_state_t` (`IDLE`, `STREAM`)
  - `eda_addr_t` (packed `{i,j}`)
  - the `CNT_WIDTH` function
- Sub-module `eda_next_one_finder` (sparse mode only):
  - Inputs: M*N-bit vector and a start index.
  - Outputs: `found`, the next-set-bit index and `is_last`.
  - Pure combinational.

## Test plan
- Dense, 4×4 bitmap 0x8001, `out_ready=1`:
  - 16 consecutive beats, addresses 0x0 through 0xF.
  - `out_bit=1` only at 0x0 and 0xF; `out_last` only on 0xF.
  - `max_count=2`; `busy` falls the cycle after beat 0xF.
- Backpressure: `out_ready` toggled 1,0,0,1,… → no beat lost or duplicated, and outputs stay stable during stalls.
- Second `done_in` rise at beat 5 → `overrun=1`, the original frame completes intact, and `clr_overrun` returns `overrun` to 0.
- `done_in` rise coincident with the last-beat handshake → the next frame's first beat follows in the next cycle and `overrun` stays 0.
- Sparse, bitmap with bits 3, 6 and 12 set → 3 beats with addresses 0x3, 0x6, 0xC and `out_last` on 0xC. An all-zero bitmap gives a single beat with `out_bit=0`, `out_last=1`.
- `reset_n` pulsed low at beat 7 → all outputs at reset values the same cycle, with no further beats until a new `done_in` rise.
